// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB scheduler and its grant selector.
package cdb_pkg;
    localparam int NUM_FU = 4;
    localparam int ROB_SZ = 8;
    localparam int TAG_W  = $clog2(ROB_SZ);
    localparam int XLEN   = 32;
    localparam int FU_W   = $clog2(NUM_FU);

    typedef enum logic [FU_W-1:0] {
        FU_ALU = 2'd0,
        FU_LD  = 2'd1,
        FU_ST  = 2'd2,
        FU_FP  = 2'd3
    } FU_IDX;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic [FU_W-1:0]  fu;
    } CDB_PACKET;

    function automatic logic [FU_W:0] pend_count(input logic [NUM_FU-1:0] v);
        logic [FU_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            n = n + {{FU_W{1'b0}}, v[i]};
        end
        return n;
    endfunction
endpackage

// File: rtl/cdb_pick.sv
// cdb_pick: combinational one-of-N selector over the pending result buffers.
// CDB_AGE_PRIORITY_EN picks the oldest ROB tag; otherwise round-robin from rr_ptr.
module cdb_pick #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 3,
    parameter int PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]            pend,
    input  logic [PTR_W-1:0]             rr_ptr,
    input  logic [NUM_FU-1:0][TAG_W-1:0] tag,
    input  logic [TAG_W-1:0]             rob_head,
    output logic [NUM_FU-1:0]            grant,
    output logic [PTR_W-1:0]             grant_idx
);
    import cdb_pkg::*;

    logic             found_s;
    logic             hit_s;
    logic [PTR_W-1:0] idx_s;

`ifdef CDB_AGE_PRIORITY_EN
    logic [TAG_W-1:0] best_s;
    logic [TAG_W-1:0] age_s;
    logic             unused_s;
    assign unused_s = ^rr_ptr;

    // Smallest wrapped distance from the ROB head wins; strict compare keeps ties on the lower unit.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = '0;
        best_s  = '0;
        age_s   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            age_s   = tag[i] - rob_head;
            hit_s   = pend[i] & (~found_s | (age_s < best_s));
            best_s  = hit_s ? age_s : best_s;
            idx_s   = hit_s ? PTR_W'(i) : idx_s;
            found_s = found_s | hit_s;
        end
    end
`else
    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] cand_s;
    logic             unused_s;
    assign unused_s = ^{tag, rob_head};

    // Scan units starting at rr_ptr, wrapping modulo NUM_FU; first pending one wins.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = '0;
        sum_s   = '0;
        cand_s  = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            sum_s   = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            cand_s  = (sum_s >= (PTR_W+1)'(NUM_FU)) ? PTR_W'(sum_s - (PTR_W+1)'(NUM_FU))
                                                   : sum_s[PTR_W-1:0];
            hit_s   = pend[cand_s] & ~found_s;
            idx_s   = hit_s ? cand_s : idx_s;
            found_s = found_s | hit_s;
        end
    end
`endif

    assign grant     = found_s ? (NUM_FU'(1'b1) << idx_s) : '0;
    assign grant_idx = idx_s;
endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: one holding buffer per functional unit, one registered CDB broadcast per cycle.
// Build option CDB_AGE_PRIORITY_EN selects oldest-tag-first arbitration instead of round-robin.
module cdb_scheduler #(
    parameter int NUM_FU = 4,
    parameter int ROB_SZ = 8,
    parameter int TAG_W  = $clog2(ROB_SZ),
    parameter int XLEN   = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_FU-1:0]            fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]            fu_ready,
    input  logic [TAG_W-1:0]             rob_head,
    input  logic                         squash,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [XLEN-1:0]              cdb_value,
    output logic [$clog2(NUM_FU)-1:0]    cdb_fu,
    output logic [15:0]                  cdb_stall_cnt
);
    import cdb_pkg::*;
    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]            pend_r;
    logic [NUM_FU-1:0][TAG_W-1:0] tag_r;
    logic [NUM_FU-1:0][XLEN-1:0]  value_r;
    logic [NUM_FU-1:0]            grant_s;
    logic [NUM_FU-1:0]            take_s;
    logic [PTR_W-1:0]             grant_idx_s;
    logic [PTR_W-1:0]             rr_ptr_s;
    logic                         any_s;
    logic                         contend_s;
    CDB_PACKET                    cdb_r;
    logic [15:0]                  stall_r;

    assign any_s     = |pend_r;
    assign contend_s = pend_count(pend_r) > 3'd1;
    // A draining buffer may refill in the same cycle, so uncontested units sustain one result per cycle.
    assign fu_ready  = {NUM_FU{~reset & ~squash}} & (~pend_r | grant_s);
    assign take_s    = fu_valid & fu_ready;

    cdb_pick #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_pick (
        .pend      (pend_r),
        .rr_ptr    (rr_ptr_s),
        .tag       (tag_r),
        .rob_head  (rob_head),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

`ifdef CDB_AGE_PRIORITY_EN
    assign rr_ptr_s = '0;
`else
    logic [PTR_W-1:0] rr_ptr_r;
    assign rr_ptr_s = rr_ptr_r;

    // Round-robin pointer: one past the last granted unit, restarted by squash.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (squash) begin
            rr_ptr_r <= '0;
        end else if (any_s) begin
            rr_ptr_r <= (grant_idx_s == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx_s + PTR_W'(1);
        end
    end
`endif

    // Holding buffers and CDB packet; squash overrides both capture and broadcast.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_r  <= '0;
            tag_r   <= '0;
            value_r <= '0;
            cdb_r   <= '0;
        end else if (squash) begin
            pend_r      <= '0;
            cdb_r.valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (take_s[i]) begin
                    pend_r[i]  <= 1'b1;
                    tag_r[i]   <= fu_tag[i];
                    value_r[i] <= fu_value[i];
                end else if (grant_s[i]) begin
                    pend_r[i] <= 1'b0;
                end
            end
            cdb_r.valid <= any_s;
            if (any_s) begin
                cdb_r.tag   <= tag_r[grant_idx_s];
                cdb_r.value <= value_r[grant_idx_s];
                cdb_r.fu    <= grant_idx_s;
            end
        end
    end

    // Saturating count of cycles where some pending result lost arbitration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_r <= '0;
        end else if (!squash && contend_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end
    end

    assign cdb_valid     = cdb_r.valid;
    assign cdb_tag       = cdb_r.tag;
    assign cdb_value     = cdb_r.value;
    assign cdb_fu        = cdb_r.fu;
    assign cdb_stall_cnt = stall_r;
endmodule
